cavlc_scan_ctrl: RTL and testbench

Sequencer for the per-block coefficient scan in the CAVLC encoder. On each block request it reads the zigzag-ordered coefficient buffer in reverse scan order and drives the total-coefficient counter (its clear and count enables, plus the coefficient stream). In the same pass it computes TrailingOnes and TotalZeros. It then presents {TotalCoeff, TrailingOnes, TotalZeros} to the coeff_token/total_zeros encoder over a valid/ready handshake.

---
 rtl/cavlc_pkg.sv | 52 +++++
 rtl/cavlc_scan_ctrl_if.sv | 33 +++
 rtl/cavlc_t1_tz_tracker.sv | 50 +++++
 rtl/cavlc_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_cavlc_scan_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// Shared types and block-geometry helpers for the CAVLC coefficient scan sequencer.
package cavlc_pkg;

    typedef enum logic [1:0] {
        BLK_LUMA = 2'd0,
        BLK_AC   = 2'd1,
        BLK_DC   = 2'd2,
        BLK_RSV  = 2'd3
    } blk_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_SCAN = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } scan_state_e;

    localparam int LUMA_N = 16;
    localparam int AC_N   = 15;
    localparam int DC_N   = 4;

    // Lowest zigzag index that belongs to the block (AC blocks skip the DC term).
    function automatic logic [3:0] blk_first_idx(input blk_type_e t);
        logic [3:0] idx;
        case (t)
            BLK_AC:  idx = 4'd1;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] blk_last_idx(input blk_type_e t);
        logic [3:0] idx;
        case (t)
            BLK_DC:  idx = 4'd3;
            default: idx = 4'd15;
        endcase
        return idx;
    endfunction

    function automatic logic [4:0] blk_len(input blk_type_e t);
        logic [4:0] n;
        case (t)
            BLK_AC:  n = 5'(AC_N);
            BLK_DC:  n = 5'(DC_N);
            default: n = 5'(LUMA_N);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cavlc_scan_ctrl_if.sv
// Block request, coefficient buffer, counter and result handshake bundle of the scan sequencer.
interface cavlc_scan_ctrl_if #(
    parameter int COEFF_W = 8,
    parameter int CNT_W   = 5
);
    logic               blk_start_i;
    logic [1:0]         blk_type_i;
    logic               blk_ready_o;
    logic               coeff_rd_o;
    logic [3:0]         coeff_addr_o;
    logic [COEFF_W-1:0] coeff_rdata_i;
    logic               cnt_rst_o;
    logic               start_cnt_o;
    logic [COEFF_W-1:0] coeff_o;
    logic [CNT_W-1:0]   total_coeff_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [CNT_W-1:0]   out_total_coeff_o;
    logic [1:0]         out_trailing_ones_o;
    logic [3:0]         out_total_zeros_o;

    modport master (
        input  blk_start_i, blk_type_i, coeff_rdata_i, total_coeff_i, out_ready_i,
        output blk_ready_o, coeff_rd_o, coeff_addr_o, cnt_rst_o, start_cnt_o, coeff_o,
               out_valid_o, out_total_coeff_o, out_trailing_ones_o, out_total_zeros_o
    );

    modport slave (
        output blk_start_i, blk_type_i, coeff_rdata_i, total_coeff_i, out_ready_i,
        input  blk_ready_o, coeff_rd_o, coeff_addr_o, cnt_rst_o, start_cnt_o, coeff_o,
               out_valid_o, out_total_coeff_o, out_trailing_ones_o, out_total_zeros_o
    );
endinterface

// File: rtl/cavlc_t1_tz_tracker.sv
// TrailingOnes / TotalZeros accumulation over a reverse-order coefficient stream.
module cavlc_t1_tz_tracker #(
    parameter int COEFF_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [COEFF_W-1:0] coeff,
    output logic [1:0]         t1,
    output logic [3:0]         tz
);
    localparam logic [COEFF_W-1:0] PLUS_ONE  = COEFF_W'(1);
    localparam logic [COEFF_W-1:0] MINUS_ONE = {COEFF_W{1'b1}};

    logic nz_s;
    logic pm1_s;
    logic t1_stop_r;
    logic seen_nz_r;

    // Classify the current datum.
    always_comb begin
        nz_s  = (coeff != {COEFF_W{1'b0}});
        pm1_s = (coeff == PLUS_ONE) || (coeff == MINUS_ONE);
    end

    // Trailing-ones run stops at the first non-unit nonzero; zeros count only below the highest nonzero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            t1        <= 2'd0;
            tz        <= 4'd0;
            t1_stop_r <= 1'b0;
            seen_nz_r <= 1'b0;
        end else if (en) begin
            if (nz_s) begin
                seen_nz_r <= 1'b1;
                if (!t1_stop_r) begin
                    if (pm1_s && (t1 != 2'd3)) begin
                        t1 <= t1 + 2'd1;
                    end else begin
                        t1_stop_r <= 1'b1;
                    end
                end
            end else if (seen_nz_r) begin
                tz <= tz + 4'd1;
            end
        end
    end

endmodule

// File: rtl/cavlc_scan_ctrl.sv
// Per-block reverse-zigzag scan sequencer: drives the coefficient counter and reports
// {TotalCoeff, TrailingOnes, TotalZeros} over a valid/ready handshake.
module cavlc_scan_ctrl
    import cavlc_pkg::*;
#(
    parameter int COEFF_W = 8,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    cavlc_scan_ctrl_if.master   bus
);
    scan_state_e      state_r;
    blk_type_e        type_r;
    logic [4:0]       left_r;
    logic             blk_ready_r;
    logic             coeff_rd_r;
    logic [3:0]       addr_r;
    logic             cnt_rst_r;
    logic             start_cnt_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] out_tc_r;
    logic [1:0]       out_t1_r;
    logic [3:0]       out_tz_r;
    logic [1:0]       t1_s;
    logic [3:0]       tz_s;
    blk_type_e        req_type_s;

    assign req_type_s = blk_type_e'(bus.blk_type_i);

    cavlc_t1_tz_tracker #(.COEFF_W(COEFF_W)) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_rst_r),
        .en    (start_cnt_r),
        .coeff (bus.coeff_rdata_i),
        .t1    (t1_s),
        .tz    (tz_s)
    );

    // Sequencer FSM; every strobe is registered so it lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            type_r      <= BLK_LUMA;
            left_r      <= 5'd0;
            blk_ready_r <= 1'b0;
            coeff_rd_r  <= 1'b0;
            addr_r      <= 4'd0;
            cnt_rst_r   <= 1'b0;
            start_cnt_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_tc_r    <= {CNT_W{1'b0}};
            out_t1_r    <= 2'd0;
            out_tz_r    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (blk_ready_r && bus.blk_start_i && (req_type_s != BLK_RSV)) begin
                        type_r      <= req_type_s;
                        left_r      <= blk_len(req_type_s);
                        addr_r      <= blk_last_idx(req_type_s);
                        coeff_rd_r  <= 1'b1;
                        cnt_rst_r   <= 1'b1;
                        blk_ready_r <= 1'b0;
                        state_r     <= ST_CLR;
                    end else begin
                        blk_ready_r <= 1'b1;
                    end
                end
                ST_CLR: begin
                    cnt_rst_r   <= 1'b0;
                    start_cnt_r <= 1'b1;
                    addr_r      <= addr_r - 4'd1;
                    coeff_rd_r  <= 1'b1;
                    state_r     <= ST_SCAN;
                end
                ST_SCAN: begin
                    left_r <= left_r - 5'd1;
                    if (left_r == 5'd1) begin
                        start_cnt_r <= 1'b0;
                        coeff_rd_r  <= 1'b0;
                        state_r     <= ST_WAIT;
                    end else if (coeff_rd_r && (addr_r != blk_first_idx(type_r))) begin
                        // Reads run one ahead of the data, so the first index is fetched one cycle early.
                        addr_r     <= addr_r - 4'd1;
                        coeff_rd_r <= 1'b1;
                    end else begin
                        coeff_rd_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    out_tc_r    <= bus.total_coeff_i;
                    out_t1_r    <= t1_s;
                    out_tz_r    <= tz_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready_i) begin
                        out_valid_r <= 1'b0;
                        blk_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    coeff_rd_r  <= 1'b0;
                    cnt_rst_r   <= 1'b0;
                    start_cnt_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    blk_ready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data goes straight to the counter so it is counted in the cycle it arrives.
    always_comb begin
        if (start_cnt_r) begin
            bus.coeff_o = bus.coeff_rdata_i;
        end else begin
            bus.coeff_o = {COEFF_W{1'b0}};
        end
    end

    assign bus.blk_ready_o         = blk_ready_r;
    assign bus.coeff_rd_o          = coeff_rd_r;
    assign bus.coeff_addr_o        = addr_r;
    assign bus.cnt_rst_o           = cnt_rst_r;
    assign bus.start_cnt_o         = start_cnt_r;
    assign bus.out_valid_o         = out_valid_r;
    assign bus.out_total_coeff_o   = out_tc_r;
    assign bus.out_trailing_ones_o = out_t1_r;
    assign bus.out_total_zeros_o   = out_tz_r;

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Self-checking bench for cavlc_scan_ctrl with a buffer model, an external counter and a result model.
module tb_cavlc_scan_ctrl;
    localparam int COEFF_W = 8;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cavlc_scan_ctrl_if #(.COEFF_W(COEFF_W), .CNT_W(CNT_W)) bus();
    cavlc_scan_ctrl #(.COEFF_W(COEFF_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]       mem [16];
    logic [7:0]       rdata_r;
    logic [CNT_W-1:0] cnt_r;
    int cyc = 0, n_start = 0, n_clr = 0, n_rd = 0;
    int addr_q[$];
    int checks = 0, failures = 0;
    int exp_tc, exp_t1, exp_tz, exp_first, exp_last;

    // Coefficient buffer with one-cycle read latency.
    always @(posedge clk) if (bus.coeff_rd_o) rdata_r <= mem[bus.coeff_addr_o];
    assign bus.coeff_rdata_i = rdata_r;

    // External total-coefficient counter.
    always @(posedge clk) begin
        if (rst || bus.cnt_rst_o) cnt_r <= '0;
        else if (bus.start_cnt_o && (bus.coeff_o != 8'd0)) cnt_r <= cnt_r + 5'd1;
    end
    assign bus.total_coeff_i = cnt_r;

    // Activity monitor: strobe counts and the read address trace.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.start_cnt_o) n_start <= n_start + 1;
            if (bus.cnt_rst_o)   n_clr   <= n_clr + 1;
            if (bus.coeff_rd_o) begin
                n_rd <= n_rd + 1;
                addr_q.push_back(int'(bus.coeff_addr_o));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result model: counts from the coefficient layout itself.
    task automatic model(input int t, output int tc, output int t1, output int tz);
        int first, last, hi;
        int nz_rev[$];
        first = (t == 1) ? 1 : 0;
        last  = (t == 2) ? 3 : 15;
        tc = 0; hi = -1; tz = 0; t1 = 0;
        for (int i = first; i <= last; i++) if (mem[i] != 8'd0) begin tc++; hi = i; end
        for (int i = first; i < hi; i++) if (mem[i] == 8'd0) tz++;
        for (int i = last; i >= first; i--) if (mem[i] != 8'd0) nz_rev.push_back(int'(mem[i]));
        for (int j = 0; j < nz_rev.size() && j < 3; j++) begin
            if (nz_rev[j] == 8'h01 || nz_rev[j] == 8'hFF) t1++;
            else break;
        end
        exp_first = first;
        exp_last  = last;
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            chk("coeff_o", int'(bus.coeff_o), bus.start_cnt_o ? int'(bus.coeff_rdata_i) : 0);
            if (bus.out_valid_o) begin
                chk("out_total_coeff", int'(bus.out_total_coeff_o), exp_tc);
                chk("out_trailing_ones", int'(bus.out_trailing_ones_o), exp_t1);
                chk("out_total_zeros", int'(bus.out_total_zeros_o), exp_tz);
            end
            if (bus.coeff_rd_o && (int'(bus.coeff_addr_o) < exp_first || int'(bus.coeff_addr_o) > exp_last))
                chk("rd_addr_range", int'(bus.coeff_addr_o), exp_first);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    endtask

    task automatic run_block(input int t, input int hold, input bit poke,
                             input int pin_tc, input int pin_t1, input int pin_tz);
        int s0, c0, r0, q0, t0, len, got;
        len = (t == 0) ? 16 : (t == 1) ? 15 : 4;
        model(t, exp_tc, exp_t1, exp_tz);
        chk("model_pin_tc", exp_tc, pin_tc);
        chk("model_pin_t1", exp_t1, pin_t1);
        chk("model_pin_tz", exp_tz, pin_tz);
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.blk_ready_o) begin got = 1; break; end
            tick();
        end
        chk("ready_wait", got, 1);
        s0 = n_start; c0 = n_clr; r0 = n_rd; q0 = addr_q.size(); t0 = cyc;
        bus.blk_type_i  = 2'(t);
        bus.blk_start_i = 1'b1;
        tick();
        bus.blk_start_i = 1'b0;
        chk("ready_low_busy", int'(bus.blk_ready_o), 0);
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid_o) begin got = 1; break; end
            tick();
        end
        chk("valid_wait", got, 1);
        chk("latency", cyc - t0, len + 3);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin bus.blk_start_i = 1'b1; bus.blk_type_i = 2'd0; end
            tick();
            chk("valid_held", int'(bus.out_valid_o), 1);
        end
        bus.blk_start_i = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("valid_drop", int'(bus.out_valid_o), 0);
        chk("ready_after_hs", int'(bus.blk_ready_o), 1);
        chk("start_cnt_pulses", n_start - s0, len);
        chk("cnt_rst_pulses", n_clr - c0, 1);
        chk("read_count", n_rd - r0, len);
        for (int i = 0; i < len && (q0 + i) < addr_q.size(); i++)
            chk("read_order", addr_q[q0 + i], exp_last - i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_blk_ready"}, int'(bus.blk_ready_o), 0);
        chk({tag, "_coeff_rd"}, int'(bus.coeff_rd_o), 0);
        chk({tag, "_addr"}, int'(bus.coeff_addr_o), 0);
        chk({tag, "_cnt_rst"}, int'(bus.cnt_rst_o), 0);
        chk({tag, "_start_cnt"}, int'(bus.start_cnt_o), 0);
        chk({tag, "_coeff_o"}, int'(bus.coeff_o), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid_o), 0);
        chk({tag, "_out_fields"}, int'({bus.out_total_coeff_o, bus.out_trailing_ones_o, bus.out_total_zeros_o}), 0);
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        bus.blk_start_i = 1'b0;
        bus.blk_type_i  = 2'd0;
        bus.out_ready_i = 1'b0;
        exp_first = 0; exp_last = 15; exp_tc = 0; exp_t1 = 0; exp_tz = 0;
        clear_mem();
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", int'(bus.blk_ready_o), 1);

        // Luma, all zeros.
        run_block(0, 0, 1'b0, 0, 0, 0);

        // Luma: zeros below the highest nonzero sit at idx 7,4,3,0.
        clear_mem();
        mem[1] = 8'h03; mem[2] = 8'hFF; mem[5] = 8'hFF; mem[6] = 8'h01; mem[8] = 8'h01;
        run_block(0, 0, 1'b0, 5, 3, 4);

        // Luma, single +1 at the last index.
        clear_mem();
        mem[15] = 8'h01;
        run_block(0, 1, 1'b0, 1, 1, 15);

        // AC block; idx 0 carries junk that must never be read.
        clear_mem();
        mem[0] = 8'h05;
        mem[1] = 8'h01; mem[3] = 8'h02; mem[4] = 8'h01; mem[5] = 8'hFF; mem[6] = 8'h01;
        run_block(1, 0, 1'b0, 5, 3, 1);

        // Chroma DC with backpressure and a stray request during OUT.
        clear_mem();
        mem[0] = 8'hFE; mem[1] = 8'h01; mem[2] = 8'h01;
        run_block(2, 5, 1'b1, 3, 2, 0);

        // Reserved type is ignored.
        c0 = n_clr;
        bus.blk_type_i  = 2'd3;
        bus.blk_start_i = 1'b1;
        tick();
        bus.blk_start_i = 1'b0;
        chk("rsv_ready", int'(bus.blk_ready_o), 1);
        repeat (3) tick();
        chk("rsv_no_clr", n_clr - c0, 0);
        chk("rsv_no_valid", int'(bus.out_valid_o), 0);

        // Reset in the middle of a luma scan.
        clear_mem();
        mem[2] = 8'h07; mem[9] = 8'hFF;
        model(0, exp_tc, exp_t1, exp_tz);
        bus.blk_type_i  = 2'd0;
        bus.blk_start_i = 1'b1;
        tick();
        bus.blk_start_i = 1'b0;
        repeat (5) tick();
        chk("midscan_start_cnt", int'(bus.start_cnt_o), 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midscan_rst");
        rst = 1'b0;
        tick();
        chk("ready_after_midscan_rst", int'(bus.blk_ready_o), 1);
        chk("no_valid_after_rst", int'(bus.out_valid_o), 0);

        // Fresh luma block after the abort.
        clear_mem();
        mem[0] = 8'h01; mem[4] = 8'hFF; mem[10] = 8'h02; mem[12] = 8'h01;
        run_block(0, 2, 1'b0, 4, 1, 9);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
